// File: rtl/sram_ctrl_pkg.sv
// Shared types and default sizes for the SRAM access sequencer.
package sram_ctrl_pkg;

  // Sequencer states: wait for a request, hold the strobe, pulse done.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int SRAM_ADDR_W           = 16;
  localparam int SRAM_DATA_W           = 128;
  localparam int DEFAULT_ACCESS_CYCLES = 2;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. Combinational; the caller owns the
// last_grant flop and updates it whenever a grant is taken.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_id
);

  // A lone requester wins outright; on a tie the one not served last wins.
  always_comb begin
    grant_valid = |req;
    grant_id    = (req == 2'b11) ? ~last_grant : req[1];
  end

endmodule

// File: rtl/sram_access_arbiter.sv
// Shares one SRAM wrapper between the host side (requester 0) and the
// cipher datapath (requester 1). Turns a level req / one-cycle done
// handshake into level read/write enables held for ACCESS_CYCLES clocks,
// registers read data, and alternates grants when both ask at once.
module sram_access_arbiter
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W        = SRAM_ADDR_W,
  parameter int DATA_W        = SRAM_DATA_W,
  parameter int ACCESS_CYCLES = DEFAULT_ACCESS_CYCLES
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              req0,
  input  logic              wr0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              done0,
  input  logic              req1,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              sram_read,
  output logic              sram_write,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  // Counter is wide enough to hold ACCESS_CYCLES, so the increment on the
  // final access cycle never wraps before IDLE clears it.
  localparam int CNT_W = (ACCESS_CYCLES < 1) ? 1 : $clog2(ACCESS_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              op_write;
  logic              cur_id;
  logic              last_grant;

  logic              grant_valid;
  logic              grant_id;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_arb2 u_arb (
    .req         ({req1, req0}),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Route the winning requester's command toward the capture registers.
  always_comb begin
    sel_wr    = grant_id ? wr1    : wr0;
    sel_addr  = grant_id ? addr1  : addr0;
    sel_wdata = grant_id ? wdata1 : wdata0;
  end

  // Sequencer: all outputs are registered so the wrapper sees clean,
  // glitch-free enables that are low in both DONE and the following IDLE.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      cnt        <= '0;
      op_write   <= 1'b0;
      cur_id     <= 1'b0;
      last_grant <= 1'b1;
      sram_read  <= 1'b0;
      sram_write <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      rdata      <= '0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (grant_valid) begin
            sram_addr  <= sel_addr;
            sram_wdata <= sel_wdata;
            op_write   <= sel_wr;
            cur_id     <= grant_id;
            last_grant <= grant_id;
            sram_read  <= ~sel_wr;
            sram_write <= sel_wr;
            busy       <= 1'b1;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            if (!op_write) begin
              rdata <= sram_rdata;
            end
            sram_read  <= 1'b0;
            sram_write <= 1'b0;
            done0      <= ~cur_id;
            done1      <= cur_id;
            state      <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          sram_read  <= 1'b0;
          sram_write <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
